rgb_conv_sequencer: RTL and testbench

// - Frame-level controller for the 3-phase YUV->RGB converter datapath: fetches {Y,U,V} triplets from an upstream

---
 rtl/rgb_conv_sequencer_pkg.sv | 34 +++
 rtl/rgb_conv_sequencer_if.sv | 41 ++++
 rtl/rgb_conv_sequencer_out_fifo.sv | 53 +++++
 rtl/rgb_conv_sequencer.sv | 122 ++++++++++++
 tb/tb_rgb_conv_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_conv_sequencer_pkg.sv
// Shared types and helpers for the YUV->RGB conversion sequencer.
package rgb_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PH_Y,
        ST_PH_V,
        ST_PH_U,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] PH_Y = 2'b00;
    localparam logic [1:0] PH_V = 2'b01;
    localparam logic [1:0] PH_U = 2'b10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Accumulator sums carry the colour in [23:16]; negative saturates low, overflow high.
    function automatic logic [7:0] clip8(input logic [31:0] sum, input logic clip_en);
        if (!clip_en)
            return sum[23:16];
        if (sum[31])
            return '0;
        if (|sum[30:24])
            return '1;
        return sum[23:16];
    endfunction

endpackage

// File: rtl/rgb_conv_sequencer_if.sv
// Control, upstream YUV stream, converter and RGB output signals of the sequencer.
interface rgb_conv_sequencer_if #(
    parameter int unsigned PIX_W = 18
);
    logic             start;
    logic [PIX_W-1:0] pixel_count;
    logic             busy;
    logic             done;

    logic             yuv_valid;
    logic             yuv_ready;
    logic [23:0]      yuv_data;

    logic             conv_enable;
    logic [1:0]       conv_phase;
    logic [31:0]      conv_y;
    logic [31:0]      conv_u;
    logic [31:0]      conv_v;
    logic [31:0]      conv_r_sum;
    logic [31:0]      conv_g_sum;
    logic [31:0]      conv_b_sum;

    logic             rgb_valid;
    logic             rgb_ready;
    logic [23:0]      rgb_data;

    // master: the sequencer; slave: its surroundings (fetch, converter, writer)
    modport master (
        input  start, pixel_count, yuv_valid, yuv_data,
        input  conv_r_sum, conv_g_sum, conv_b_sum, rgb_ready,
        output busy, done, yuv_ready, conv_enable, conv_phase,
        output conv_y, conv_u, conv_v, rgb_valid, rgb_data
    );

    modport slave (
        output start, pixel_count, yuv_valid, yuv_data,
        output conv_r_sum, conv_g_sum, conv_b_sum, rgb_ready,
        input  busy, done, yuv_ready, conv_enable, conv_phase,
        input  conv_y, conv_u, conv_v, rgb_valid, rgb_data
    );
endinterface

// File: rtl/rgb_conv_sequencer_out_fifo.sv
// Two-entry FIFO of packed RGB pixels with occupancy count.
module rgb_out_fifo
    import rgb_seq_pkg::*;
(
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  rgb_t       in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output rgb_t       out_data,
    output logic [1:0] count
);
    rgb_t mem [2];
    logic wr_ptr;
    logic rd_ptr;
    logic push;
    logic pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // The sequencer only accepts input with a free slot, so a push never meets a full buffer.
    a_no_overflow: assert property (@(posedge CLOCK_50_I) disable iff (!resetn)
        !(in_valid && !in_ready));

endmodule

// File: rtl/rgb_conv_sequencer.sv
// Frame sequencer: fetches YUV triplets, steps the converter Y->V->U, clips sums, queues RGB.
module rgb_conv_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int unsigned PIX_W   = 18,
    parameter bit          CLIP_EN = 1'b1
) (
    input logic                  CLOCK_50_I,
    input logic                  resetn,
    rgb_conv_sequencer_if.master bus
);
    state_t           state;
    state_t           next_state;
    logic [PIX_W-1:0] remaining;
    logic             done_q;
    logic [7:0]       y_q;
    logic [7:0]       u_q;
    logic [7:0]       v_q;
    logic [7:0]       r_q;
    logic             start_acc;
    logic             hs;
    logic             pop;
    logic             push;
    logic             drain_exit;
    logic             fifo_in_ready;
    logic [1:0]       fifo_count;
    rgb_t             push_data;

    // done_q keeps busy high through the done cycle and blocks a restart in that cycle
    assign start_acc  = bus.start && (state == ST_IDLE) && !done_q;
    assign hs         = bus.yuv_valid && bus.yuv_ready;
    assign pop        = bus.rgb_valid && bus.rgb_ready;
    assign drain_exit = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop);
    assign push_data  = '{r: r_q,
                          g: clip8(bus.conv_g_sum, CLIP_EN),
                          b: clip8(bus.conv_b_sum, CLIP_EN)};

    assign bus.busy   = (state != ST_IDLE) || done_q;
    assign bus.done   = done_q;
    assign bus.conv_y = {24'd0, y_q};
    assign bus.conv_u = {24'd0, u_q};
    assign bus.conv_v = {24'd0, v_q};

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:  if (start_acc && (bus.pixel_count != '0)) next_state = ST_LOAD;
            ST_LOAD:  if (hs) next_state = ST_PH_Y;
            ST_PH_Y:  next_state = ST_PH_V;
            ST_PH_V:  next_state = ST_PH_U;
            ST_PH_U:  next_state = (remaining == PIX_W'(1)) ? ST_DRAIN : ST_LOAD;
            ST_DRAIN: if (drain_exit) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.yuv_ready   = 1'b0;
        bus.conv_enable = 1'b0;
        bus.conv_phase  = PH_Y;
        push            = 1'b0;
        unique case (state)
            ST_LOAD: bus.yuv_ready = fifo_in_ready;
            ST_PH_Y: bus.conv_enable = 1'b1;
            ST_PH_V: begin
                bus.conv_enable = 1'b1;
                bus.conv_phase  = PH_V;
            end
            ST_PH_U: begin
                bus.conv_enable = 1'b1;
                bus.conv_phase  = PH_U;
                push            = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            remaining <= '0;
            done_q    <= 1'b0;
            y_q       <= '0;
            u_q       <= '0;
            v_q       <= '0;
            r_q       <= '0;
        end else begin
            done_q <= (start_acc && (bus.pixel_count == '0)) ||
                      ((state == ST_DRAIN) && drain_exit);
            if (start_acc)
                remaining <= bus.pixel_count;
            else if (state == ST_PH_U)
                remaining <= remaining - PIX_W'(1);
            if (hs) begin
                y_q <= bus.yuv_data[23:16];
                u_q <= bus.yuv_data[15:8];
                v_q <= bus.yuv_data[7:0];
            end
            if (state == ST_PH_V)
                r_q <= clip8(bus.conv_r_sum, CLIP_EN);
        end
    end

    rgb_out_fifo u_out_fifo (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .in_valid   (push),
        .in_ready   (fifo_in_ready),
        .in_data    (push_data),
        .out_valid  (bus.rgb_valid),
        .out_ready  (bus.rgb_ready),
        .out_data   (bus.rgb_data),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_rgb_conv_sequencer.sv
// Directed bench for rgb_conv_sequencer: clip vectors plus multi-cycle frame sequences.
module tb_rgb_conv_sequencer;
    import rgb_seq_pkg::*;

    localparam int unsigned PIX_W = 18;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    rgb_conv_sequencer_if #(.PIX_W(PIX_W)) bus ();
    rgb_conv_sequencer_if #(.PIX_W(PIX_W)) bus_nc ();

    rgb_conv_sequencer #(.PIX_W(PIX_W), .CLIP_EN(1'b1)) u_dut (
        .CLOCK_50_I (clk),
        .resetn     (resetn),
        .bus        (bus)
    );

    rgb_conv_sequencer #(.PIX_W(PIX_W), .CLIP_EN(1'b0)) u_dut_nc (
        .CLOCK_50_I (clk),
        .resetn     (resetn),
        .bus        (bus_nc)
    );

    // Converter model: fixed sums for clip vectors, or sums that reproduce {Y,U,V} as {R,G,B}
    logic        model_mode = 1'b0;
    logic [31:0] fix_r = '0, fix_g = '0, fix_b = '0;
    assign bus.conv_r_sum = model_mode ? (bus.conv_y << 16) : fix_r;
    assign bus.conv_g_sum = model_mode ? (bus.conv_u << 16) : fix_g;
    assign bus.conv_b_sum = model_mode ? (bus.conv_v << 16) : fix_b;

    assign bus_nc.start       = bus.start;
    assign bus_nc.pixel_count = bus.pixel_count;
    assign bus_nc.yuv_valid   = bus.yuv_valid;
    assign bus_nc.yuv_data    = bus.yuv_data;
    assign bus_nc.conv_r_sum  = bus.conv_r_sum;
    assign bus_nc.conv_g_sum  = bus.conv_g_sum;
    assign bus_nc.conv_b_sum  = bus.conv_b_sum;
    assign bus_nc.rgb_ready   = bus.rgb_ready;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor state, sampled on the falling edge
    int          cyc = 0;
    int          done_cnt = 0, hs_cnt = 0, conv_cnt = 0, yr_cnt = 0;
    int          last_pop_cyc = 0, last_done_cyc = 0, first_rv_cyc = -1, hs_first_cyc = -1;
    logic        fire = 1'b0;
    logic [23:0] got[$];
    logic [23:0] got_nc[$];
    logic [1:0]  ph_log[$];
    logic [31:0] last_cy = '0, last_cu = '0, last_cv = '0;

    always @(negedge clk) begin
        cyc++;
        if (resetn) begin
            if (bus.rgb_valid && bus.rgb_ready) begin
                got.push_back(bus.rgb_data);
                last_pop_cyc = cyc;
            end
            if (bus_nc.rgb_valid && bus_nc.rgb_ready)
                got_nc.push_back(bus_nc.rgb_data);
            if (bus.done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (bus.conv_enable) begin
                conv_cnt++;
                ph_log.push_back(bus.conv_phase);
                if (bus.conv_phase == PH_Y) begin
                    last_cy = bus.conv_y;
                    last_cu = bus.conv_u;
                    last_cv = bus.conv_v;
                end
            end
            if (bus.yuv_ready)
                yr_cnt++;
            if (bus.yuv_valid && bus.yuv_ready) begin
                hs_cnt++;
                fire = 1'b1;
                if (hs_first_cyc < 0) hs_first_cyc = cyc;
            end
            if (bus.rgb_valid && first_rv_cyc < 0)
                first_rv_cyc = cyc;
        end
    end

    // Upstream source: presents feed[] in order, advancing on each handshake
    logic [23:0] feed[$];
    int          feed_idx = 0;
    logic        src_en = 1'b0;

    always @(posedge clk) begin
        #1;
        if (fire) begin
            feed_idx++;
            fire = 1'b0;
        end
        if (src_en && feed_idx < feed.size()) begin
            bus.yuv_valid = 1'b1;
            bus.yuv_data  = feed[feed_idx];
        end else begin
            bus.yuv_valid = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start(input int n);
        bus.start       = 1'b1;
        bus.pixel_count = PIX_W'(n);
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic begin_frame(input int n, input logic model, input logic const_pix);
        logic [7:0] y, u, v;
        src_en     = 1'b0;
        model_mode = model;
        got.delete();
        got_nc.delete();
        ph_log.delete();
        first_rv_cyc = -1;
        hs_first_cyc = -1;
        hs_cnt       = 0;
        fire         = 1'b0;
        feed.delete();
        for (int k = 0; k < n; k++) begin
            y = const_pix ? 8'd16  : 8'(k * 16 + 3);
            u = const_pix ? 8'd128 : 8'(8'h20 + k);
            v = const_pix ? 8'd128 : 8'(8'hF0 - k);
            feed.push_back({y, u, v});
        end
        feed_idx = 0;
        src_en   = 1'b1;
    endtask

    task automatic wait_done(input int limit, input string name);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < limit) begin
            step(1);
            k++;
        end
        check(name, done_cnt - d0, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctrl"}, {bus.busy, bus.done, bus.yuv_ready, bus.conv_enable,
                                bus.rgb_valid, bus.conv_phase}, '0);
        check({name, "_conv"}, bus.conv_y | bus.conv_u | bus.conv_v, '0);
        check({name, "_rgb"}, {8'd0, bus.rgb_data}, '0);
    endtask

    task automatic check_got_in_order(input string name);
        check({name, "_count"}, got.size(), feed.size());
        for (int k = 0; k < feed.size() && k < got.size(); k++)
            check($sformatf("%s_pix%0d", name, k), {8'd0, got[k]}, {8'd0, feed[k]});
    endtask

    typedef struct {
        logic [31:0] r, g, b;
        logic [23:0] exp_clip;
        logic [23:0] exp_noclip;
    } vec_t;
    vec_t vecs[5];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] ph_word;
        int          yr0, c0, d0, k;

        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 24'h000000, 24'h000000};
        vecs[1] = '{32'hFFFF_0000, 32'h0120_0000, 32'h00AB_1234, 24'h00FFAB, 24'hFF20AB};
        vecs[2] = '{32'h0080_0000, 32'h7FFF_FFFF, 32'h8000_0000, 24'h80FF00, 24'h80FF00};
        vecs[3] = '{32'h00FF_0000, 32'h0100_0000, 32'hFFFF_FFFF, 24'hFFFF00, 24'hFF00FF};
        vecs[4] = '{32'h0001_0000, 32'h00FF_FFFF, 32'h0000_0000, 24'h01FF00, 24'h01FF00};

        bus.start       = 1'b0;
        bus.pixel_count = '0;
        bus.rgb_ready   = 1'b1;
        bus.yuv_valid   = 1'b0;
        bus.yuv_data    = '0;

        step(3);
        check_reset_outputs("reset");
        resetn = 1'b1;
        step(2);

        // Single-pixel frames through the clip table, checked on both CLIP_EN variants
        for (int i = 0; i < 5; i++) begin
            fix_r = vecs[i].r;
            fix_g = vecs[i].g;
            fix_b = vecs[i].b;
            bus.rgb_ready = 1'b1;
            begin_frame(1, 1'b0, 1'b1);
            pulse_start(1);
            wait_done(40, $sformatf("vec%0d_done", i));
            check($sformatf("vec%0d_count", i), got.size(), 1);
            check($sformatf("vec%0d_rgb", i),
                  (got.size() > 0) ? {8'd0, got[0]} : 32'hDEAD_BEEF, {8'd0, vecs[i].exp_clip});
            check($sformatf("vec%0d_rgb_noclip", i),
                  (got_nc.size() > 0) ? {8'd0, got_nc[0]} : 32'hDEAD_BEEF, {8'd0, vecs[i].exp_noclip});
            check($sformatf("vec%0d_done_after_pop", i), last_done_cyc - last_pop_cyc, 1);
            if (i == 0) begin
                check("latency_hs_to_valid", first_rv_cyc - hs_first_cyc, 4);
                ph_word = '0;
                foreach (ph_log[j]) ph_word = {ph_word[29:0], ph_log[j]};
                check("phase_count", ph_log.size(), 3);
                check("phase_seq", ph_word, 32'b00_01_10);
                check("conv_yuv", {last_cy[7:0], last_cu[7:0], last_cv[7:0]}, 32'h0010_8080);
            end
            step(1);
            check($sformatf("vec%0d_idle", i), {bus.busy, bus.done}, '0);
        end

        // Eight pixels against a stalled writer: two buffered, input held off, then in-order release
        bus.rgb_ready = 1'b0;
        d0 = done_cnt;
        begin_frame(8, 1'b1, 1'b0);
        pulse_start(8);
        step(40);
        check("stall_accepted", hs_cnt, 2);
        check("stall_no_pop", got.size(), 0);
        check("stall_head", {7'd0, bus.rgb_valid, bus.rgb_data}, {8'd1, feed[0]});
        yr0 = yr_cnt;
        step(10);
        check("stall_yuv_ready_low", yr_cnt - yr0, 0);
        check("stall_busy_no_done", {bus.busy, 31'(done_cnt - d0)}, 32'h8000_0000);
        bus.rgb_ready = 1'b1;
        wait_done(200, "stall_done");
        check("stall_accepted_total", hs_cnt, 8);
        check_got_in_order("stall");
        step(2);

        // Zero-pixel frame: done on the next cycle, no fetch and no converter activity
        src_en = 1'b0;
        c0  = conv_cnt;
        yr0 = yr_cnt;
        d0  = done_cnt;
        pulse_start(0);
        check("zero_done_busy", {bus.done, bus.busy}, 2'b11);
        step(1);
        check("zero_after", {bus.done, bus.busy}, 2'b00);
        step(2);
        check("zero_done_once", done_cnt - d0, 1);
        check("zero_no_conv_no_ready", {16'(conv_cnt - c0), 16'(yr_cnt - yr0)}, '0);

        // Reset during phase V of the third pixel, then a clean frame
        begin_frame(5, 1'b1, 1'b0);
        pulse_start(5);
        k = 0;
        while (hs_cnt < 3 && k < 100) begin step(1); k++; end
        check("rst_reach_pix3", hs_cnt, 3);
        k = 0;
        while (!(bus.conv_enable && bus.conv_phase == PH_V) && k < 10) begin step(1); k++; end
        check("rst_reach_phv", {bus.conv_enable, bus.conv_phase}, {1'b1, PH_V});
        d0 = done_cnt;
        #1 resetn = 1'b0;
        #1 check_reset_outputs("midrst");
        src_en = 1'b0;
        step(3);
        resetn = 1'b1;
        step(3);
        check("midrst_no_done", done_cnt - d0, 0);
        begin_frame(4, 1'b1, 1'b0);
        pulse_start(4);
        wait_done(100, "postrst_done");
        check_got_in_order("postrst");
        step(2);

        // Start pulses while busy are ignored
        d0 = done_cnt;
        begin_frame(3, 1'b1, 1'b0);
        pulse_start(3);
        k = 0;
        while (bus.busy && k < 100) begin
            bus.start       = k[0];
            bus.pixel_count = PIX_W'(7);
            step(1);
            k++;
        end
        bus.start = 1'b0;
        check("busy_start_ended", bus.busy, 1'b0);
        step(20);
        check("busy_start_one_done", done_cnt - d0, 1);
        check("busy_start_accepted", hs_cnt, 3);
        check_got_in_order("busy_start");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
